// File: rtl/pslip_pkg.sv
// Shared types and default sizing for the pSLIP grant arbiter.
package pslip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        WAIT_ACC
    } state_t;

    localparam int PSLIP_N       = 16;
    localparam int PSLIP_IW      = $clog2(PSLIP_N);
    localparam int PSLIP_TIMEOUT = 15;

endpackage

// File: rtl/pslip_grant_arb_rr_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] N_VAL = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    logic          found;

    // Rotate so ptr lands at bit 0, priority-encode, then undo the rotation.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
        idx = sum[IW-1:0];
        gnt = found ? (N'(1) << idx) : '0;
        any = found;
    end

endmodule

// File: rtl/pslip_grant_arb.sv
// Round-robin grant arbiter for one pSLIP output port; pointer moves only on accept.
// Optional grant abandonment after TIMEOUT idle WAIT_ACC cycles: define PSLIP_GRANT_TIMEOUT_EN.
module pslip_grant_arb
    import pslip_pkg::*;
#(
    parameter int N       = PSLIP_N,
    parameter int IW      = $clog2(N),
    parameter int TIMEOUT = PSLIP_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_in,
    input  logic          req_valid,
    input  logic          accept_valid,
    input  logic          accept_in,
    output logic [N-1:0]  gnt_out,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          iter_done,
`ifdef PSLIP_GRANT_TIMEOUT_EN
    output logic          timeout_flag,
`endif
    output logic          busy
);

    state_t        state;
    logic [N-1:0]  req_q;
    logic [IW-1:0] ptr;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] next_ptr;

`ifdef PSLIP_GRANT_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req_q),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign next_ptr = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            ptr       <= '0;
            gnt_out   <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            iter_done <= 1'b0;
            busy      <= 1'b0;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            iter_done <= 1'b0;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= req_in;
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (pick_any) begin
                        gnt_out   <= pick_gnt;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        state     <= WAIT_ACC;
`ifdef PSLIP_GRANT_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else begin
                        iter_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                WAIT_ACC: begin
                    // A new req_valid here is deliberately dropped.
                    if (accept_valid) begin
                        if (accept_in) begin
                            ptr <= next_ptr;
                        end
                        gnt_out   <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        iter_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
`ifdef PSLIP_GRANT_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        gnt_out      <= '0;
                        gnt_idx      <= '0;
                        gnt_valid    <= 1'b0;
                        iter_done    <= 1'b1;
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pslip_grant_arb.sv
// Scoreboard bench for pslip_grant_arb (default build, timeout feature off).
module tb_pslip_grant_arb;

    localparam int N  = 16;
    localparam int IW = 4;

    typedef struct {
        bit grant;
        int idx;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_in;
    logic          req_valid;
    logic          accept_valid;
    logic          accept_in;
    logic [N-1:0]  gnt_out;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          iter_done;
    logic          busy;

    exp_t sb[$];
    int   test_count = 0;
    int   fail_count = 0;
    int   model_ptr  = 0;
    int   held_idx   = 0;
    logic prev_gv    = 1'b0;

    pslip_grant_arb #(.N(N), .IW(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .req_valid    (req_valid),
        .accept_valid (accept_valid),
        .accept_in    (accept_in),
        .gnt_out      (gnt_out),
        .gnt_idx      (gnt_idx),
        .gnt_valid    (gnt_valid),
        .iter_done    (iter_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelPick(input logic [N-1:0] req, output bit has, output int idx);
        has = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (model_ptr + k) % N;
            if (!has && req[i]) begin
                has = 1'b1;
                idx = i;
            end
        end
    endtask

    // Called at the negedge where the grant is visible; answers it and checks the wind-down.
    task automatic resolveGrant(input bit acc, input bit with_req);
        accept_valid = 1'b1;
        accept_in    = acc;
        if (with_req) begin
            req_valid = 1'b1;
            req_in    = 16'hFFFF;
        end
        @(negedge clk);
        accept_valid = 1'b0;
        accept_in    = 1'b0;
        req_valid    = 1'b0;
        req_in       = '0;
        checkOutput("gnt_cleared", {31'b0, gnt_valid}, 32'd0);
        checkOutput("gnt_out_cleared", {16'b0, gnt_out}, 32'd0);
        checkOutput("iter_done_pulse", {31'b0, iter_done}, 32'd1);
        checkOutput("idle_after_accept", {31'b0, busy}, 32'd0);
        if (acc) model_ptr = (held_idx + 1) % N;
        @(negedge clk);
        checkOutput("iter_done_one_cycle", {31'b0, iter_done}, 32'd0);
        checkOutput("no_restart", {31'b0, busy}, 32'd0);
    endtask

    // mode: 0 = accept, 1 = reject, 2 = leave grant outstanding
    task automatic applyStimulus(input logic [N-1:0] req, input int mode);
        exp_t e;
        bit   has;
        int   idx;
        modelPick(req, has, idx);
        e.grant = has;
        e.idx   = idx;
        sb.push_back(e);
        req_in    = req;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_in    = '0;
        checkOutput("arb_busy", {31'b0, busy}, 32'd1);
        checkOutput("arb_no_grant_yet", {31'b0, gnt_valid}, 32'd0);
        @(negedge clk);
        checkOutput("gnt_valid_t2", {31'b0, gnt_valid}, {31'b0, has});
        checkOutput("iter_done_t2", {31'b0, iter_done}, {31'b0, !has});
        if (has) begin
            held_idx = idx;
            if (mode != 2) resolveGrant(mode == 0, 1'b0);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    // Monitor: grant rising edges and grant-less iteration ends consume scoreboard entries.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_gv = 1'b0;
        end else begin
            if (gnt_valid)
                checkOutput("onehot_invariant", {16'b0, gnt_out}, 32'd1 << gnt_idx);
            else
                checkOutput("zero_when_invalid", {16'b0, gnt_out}, 32'd0);
            if ((gnt_valid && !prev_gv) || (iter_done && !prev_gv && !gnt_valid)) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_output", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_kind", {31'b0, gnt_valid}, {31'b0, e.grant});
                    if (e.grant) begin
                        checkOutput("sb_idx", {28'b0, gnt_idx}, 32'(e.idx));
                        checkOutput("sb_onehot", {16'b0, gnt_out}, 32'd1 << e.idx);
                    end
                end
            end
            prev_gv = gnt_valid;
        end
    end

    initial begin
        reset        = 1'b0;
        req_in       = '0;
        req_valid    = 1'b0;
        accept_valid = 1'b0;
        accept_in    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt_out", {16'b0, gnt_out}, 32'd0);
        checkOutput("rst_gnt_idx", {28'b0, gnt_idx}, 32'd0);
        checkOutput("rst_gnt_valid", {31'b0, gnt_valid}, 32'd0);
        checkOutput("rst_iter_done", {31'b0, iter_done}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset while a grant to input 5 is outstanding
        applyStimulus(16'h0020, 2);
        checkOutput("pre_reset_idx", {28'b0, gnt_idx}, 32'd5);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_gnt_valid", {31'b0, gnt_valid}, 32'd0);
        checkOutput("async_rst_gnt_out", {16'b0, gnt_out}, 32'd0);
        checkOutput("async_rst_gnt_idx", {28'b0, gnt_idx}, 32'd0);
        checkOutput("async_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        applyStimulus(16'h0020, 0);

        // Pointer advance on accept and wrap past bit 4
        resetDut();
        applyStimulus(16'h0011, 0);
        applyStimulus(16'h0011, 0);
        applyStimulus(16'h0011, 0);

        // Rejection leaves the pointer alone
        applyStimulus(16'h000C, 1);
        applyStimulus(16'h000C, 0);

        // Wrap-around from input 15 to 0
        applyStimulus(16'h4000, 0);
        applyStimulus(16'h8001, 0);
        checkOutput("wrap_model_ptr", 32'(model_ptr), 32'd0);
        applyStimulus(16'h8001, 0);

        // Empty request ends the iteration without a grant
        applyStimulus(16'h0000, 0);

        // Requests arriving during WAIT_ACC are dropped
        applyStimulus(16'h0100, 2);
        req_in    = 16'h0001;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_in    = '0;
        checkOutput("overlap_hold_idx", {28'b0, gnt_idx}, 32'(held_idx));
        checkOutput("overlap_hold_valid", {31'b0, gnt_valid}, 32'd1);
        resolveGrant(1'b1, 1'b1);

        // Single-bit request wins regardless of pointer position
        applyStimulus(16'h0002, 0);
        applyStimulus(16'h0400, 1);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
